silencer_interpolator_phase: RTL and testbench



---
 rtl/silencer_interpolator_phase_if.sv | 33 +++
 rtl/silencer_interpolator_phase.sv | 162 ++++++++++++++++
 tb/tb_silencer_interpolator_phase.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/silencer_interpolator_phase_if.sv
// Stream bus between the phase step calculator, the silencer and the output stage.
// Carries one beat per transducer: target phase and step size in, interpolated
// phase and its index out. SETTLED exists only when SILENCER_SETTLED_STATUS_EN
// is defined.
interface silencer_interpolator_phase_if;
    logic        DIN_VALID;
    logic [7:0]  PHASE;
    logic [15:0] UPDATE_RATE;
    logic [7:0]  PHASE_OUT;
    logic        DOUT_VALID;
    logic [7:0]  IDX_OUT;
`ifdef SILENCER_SETTLED_STATUS_EN
    logic        SETTLED;

    modport master (
        output DIN_VALID, PHASE, UPDATE_RATE,
        input  PHASE_OUT, DOUT_VALID, IDX_OUT, SETTLED
    );
    modport slave (
        input  DIN_VALID, PHASE, UPDATE_RATE,
        output PHASE_OUT, DOUT_VALID, IDX_OUT, SETTLED
    );
`else
    modport master (
        output DIN_VALID, PHASE, UPDATE_RATE,
        input  PHASE_OUT, DOUT_VALID, IDX_OUT
    );
    modport slave (
        input  DIN_VALID, PHASE, UPDATE_RATE,
        output PHASE_OUT, DOUT_VALID, IDX_OUT
    );
`endif
endinterface

// File: rtl/silencer_interpolator_phase.sv
// Silencer interpolator: moves each transducer's stored 8.8 phase toward its
// target along the shortest circular path by at most UPDATE_RATE per frame,
// snapping when the remaining distance fits in one step.
// Pipeline: S1 read/register, S2 circular difference, S3 update/write/output.
// Optional: SILENCER_SETTLED_STATUS_EN adds a per-frame SETTLED status output.
module silencer_interpolator_phase #(
    parameter int DEPTH = 249
) (
    input logic CLK,
    input logic RST,
    silencer_interpolator_phase_if.slave bus
);
    localparam logic [7:0] LAST_IDX = 8'(DEPTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic        idx_wrap;
    logic [7:0]  idx_q, idx_d;

    // Current phase storage; an entry not yet written since reset reads as zero.
    logic [15:0]      mem [DEPTH];
    logic [DEPTH-1:0] init_q;
    logic [15:0]      cur_rd;

    // vld_pipe_q[1] = S1 holds a beat, [2] = S2 holds a beat.
    logic [2:1]  vld_pipe_q;

    logic [7:0]  tgt1_q, idx1_q;
    logic [15:0] rate1_q, cur1_q;

    logic [7:0]  tgt2_q, idx2_q;
    logic [15:0] rate2_q, cur2_q, diff2_q;

    logic        pos3, snap3;
    logic [15:0] mag3, new_cur3;

    logic [7:0]  phase_out_q, idx_out_q;
    logic        dout_valid_q;

    // Frame tracking: state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Frame tracking: next state, a frame opens on its first beat and closes on index DEPTH-1.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.DIN_VALID) state_d = RUN;
            RUN:     if (bus.DIN_VALID && idx_q == LAST_IDX) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame tracking: outputs, flag the beat that closes the frame so the index wraps.
    always_comb begin
        idx_wrap = 1'b0;
        if (state_q == RUN && bus.DIN_VALID && idx_q == LAST_IDX) idx_wrap = 1'b1;
    end

    // Input index advances only on valid beats.
    always_comb begin
        idx_d = idx_q;
        if (bus.DIN_VALID) idx_d = idx_wrap ? 8'd0 : idx_q + 8'd1;
    end

    // Input index register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) idx_q <= 8'd0;
        else     idx_q <= idx_d;
    end

    assign cur_rd = init_q[idx_q] ? mem[idx_q] : 16'h0000;

    // S1 and S2: capture the beat with its current value, then form the circular difference.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_pipe_q <= '0;
            tgt1_q     <= '0;
            idx1_q     <= '0;
            rate1_q    <= '0;
            cur1_q     <= '0;
            tgt2_q     <= '0;
            idx2_q     <= '0;
            rate2_q    <= '0;
            cur2_q     <= '0;
            diff2_q    <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[1], bus.DIN_VALID};
            tgt1_q     <= bus.PHASE;
            idx1_q     <= idx_q;
            rate1_q    <= bus.UPDATE_RATE;
            cur1_q     <= cur_rd;
            tgt2_q     <= tgt1_q;
            idx2_q     <= idx1_q;
            rate2_q    <= rate1_q;
            cur2_q     <= cur1_q;
            diff2_q    <= {tgt1_q, 8'h00} - cur1_q;
        end
    end

    // S3 update: snap when within one step, otherwise step toward target; half turn steps up.
    always_comb begin
        pos3     = ~diff2_q[15] | (diff2_q == 16'h8000);
        mag3     = pos3 ? diff2_q : (16'h0000 - diff2_q);
        snap3    = (diff2_q == 16'h0000) | (mag3 <= rate2_q);
        new_cur3 = cur2_q - rate2_q;
        if (snap3)     new_cur3 = {tgt2_q, 8'h00};
        else if (pos3) new_cur3 = cur2_q + rate2_q;
    end

    // S3 write-back into the phase store; DEPTH >= 4 keeps it clear of the S1 read.
    always_ff @(posedge CLK) begin
        if (vld_pipe_q[2]) mem[idx2_q] <= new_cur3;
    end

    // Written-since-reset flags; clearing them is what zeroes every current value on reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                init_q         <= '0;
        else if (vld_pipe_q[2]) init_q[idx2_q] <= 1'b1;
    end

    // S3 output register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            phase_out_q  <= 8'd0;
            idx_out_q    <= 8'd0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= vld_pipe_q[2];
            if (vld_pipe_q[2]) begin
                phase_out_q <= new_cur3[15:8];
                idx_out_q   <= idx2_q;
            end
        end
    end

    assign bus.PHASE_OUT  = phase_out_q;
    assign bus.IDX_OUT    = idx_out_q;
    assign bus.DOUT_VALID = dout_valid_q;

`ifdef SILENCER_SETTLED_STATUS_EN
    logic acc_q, last_q, settled_q;

    // Accumulate "snapped" across the frame; publish one cycle after the last beat leaves.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc_q     <= 1'b0;
            last_q    <= 1'b0;
            settled_q <= 1'b0;
        end else begin
            if (vld_pipe_q[2]) acc_q <= (idx2_q == 8'd0) ? snap3 : (acc_q & snap3);
            last_q <= vld_pipe_q[2] && (idx2_q == LAST_IDX);
            if (last_q) settled_q <= acc_q;
        end
    end

    assign bus.SETTLED = settled_q;
`endif
endmodule

// File: tb/tb_silencer_interpolator_phase.sv
// Randomized/directed bench for silencer_interpolator_phase with a reference
// model computed from circular-distance arithmetic on integers.
module tb_silencer_interpolator_phase;
    localparam int DEPTH = 249;

    logic CLK, RST;
    silencer_interpolator_phase_if bus();

    silencer_interpolator_phase #(.DEPTH(DEPTH)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    typedef struct {
        int         due;
        logic [7:0] idx;
        logic [7:0] ph;
        bit         last;
        bit         fok;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         mcur[256];
    int         midx = 0;
    bit         mfok = 0;
    bit         set_exp = 0;
    bit         pend = 0;
    int         pend_due = 0;
    bit         pend_val = 0;
    logic [7:0] last_ph = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference: shortest circular move of at most r, snap when within reach.
    function automatic int model_step(input int c, input int t, input int r, output bit snapped);
        int tgt, d, mag;
        bit pos;
        tgt = t * 256;
        d = (tgt - c + 65536) % 65536;
        pos = (d <= 32768);
        mag = pos ? d : 65536 - d;
        snapped = (d == 0) || (mag <= r);
        if (snapped) return tgt;
        return pos ? (c + r) % 65536 : (c - r + 65536) % 65536;
    endfunction

    task automatic beat(input bit v, input logic [7:0] ph, input logic [15:0] rate);
        exp_t e;
        bit   sn;
        @(posedge CLK);
        #1;
        bus.DIN_VALID   = v;
        bus.PHASE       = ph;
        bus.UPDATE_RATE = rate;
        if (v) begin
            mcur[midx] = model_step(mcur[midx], int'(ph), int'(rate), sn);
            mfok = (midx == 0) ? sn : (mfok & sn);
            e.due  = cyc + 3;
            e.idx  = 8'(midx);
            e.ph   = 8'(mcur[midx] / 256);
            e.last = (midx == DEPTH - 1);
            e.fok  = mfok;
            q.push_back(e);
            midx = (midx + 1) % DEPTH;
        end
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        bus.DIN_VALID = 1'b0;
        RST = 1'b1;
        q.delete();
        foreach (mcur[i]) mcur[i] = 0;
        midx = 0;
        mfok = 0;
        set_exp = 0;
        pend = 0;
        repeat (2) @(negedge CLK);
        chk("rst_phase_out", bus.PHASE_OUT, 8'h00);
        chk("rst_idx_out", bus.IDX_OUT, 8'h00);
        chk("rst_dout_valid", bus.DOUT_VALID, 1'b0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic drain();
        repeat (6) beat(1'b0, 8'h00, 16'h0000);
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        forever begin
            @(posedge CLK);
            cyc++;
        end
    end

    // Output monitor: every cycle either the scheduled beat appears or DOUT_VALID is low.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (pend && cyc == pend_due) begin
                set_exp = pend_val;
                pend = 0;
            end
`ifdef SILENCER_SETTLED_STATUS_EN
            chk("settled", bus.SETTLED, set_exp);
`endif
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("dout_valid", bus.DOUT_VALID, 1'b1);
                chk("idx_out", bus.IDX_OUT, e.idx);
                chk("phase_out", bus.PHASE_OUT, e.ph);
                last_ph = bus.PHASE_OUT;
                if (e.last) begin
                    pend = 1;
                    pend_due = cyc + 1;
                    pend_val = e.fok;
                end
            end else begin
                chk("dout_idle", bus.DOUT_VALID, 1'b0);
            end
        end
    end

    initial begin
        RST = 1'b1;
        bus.DIN_VALID = 1'b0;
        bus.PHASE = 8'h00;
        bus.UPDATE_RATE = 16'h0000;
        foreach (mcur[i]) mcur[i] = 0;
        do_reset();

        // Ramp toward 0x40 at one LSB per frame; reaches it at frame 64, stays on 65.
        for (int f = 0; f < 65; f++) begin
            for (int i = 0; i < DEPTH; i++) beat(1'b1, 8'h40, 16'h0100);
            if (f == 0) begin
                drain();
                chk("ramp_frame1", last_ph, 8'h01);
            end
        end
        drain();
        chk("ramp_frame65", last_ph, 8'h40);

        // Even indices: 0 -> 0xF0 backwards; odd: half turn to 0x80 goes forward.
        do_reset();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i % 2 == 0) beat(1'b1, 8'hF0, 16'h0800);
                else            beat(1'b1, 8'h80, 16'h1000);
            end
            drain();
            chk("neg_move_last", last_ph, (f == 0) ? 8'hF8 : 8'hF0);
        end

        // Random targets with gaps and full-snap rate; crosses the index wrap.
        for (int i = 0; i < DEPTH + 40; i++) begin
            repeat ($urandom_range(0, 2)) beat(1'b0, 8'h00, 16'h0000);
            beat(1'b1, 8'($urandom), 16'hFFFF);
        end
        drain();

        // Random targets and rates including zero and very large steps.
        for (int i = 0; i < 2 * DEPTH; i++) begin
            case ($urandom_range(0, 3))
                0:       beat(1'b1, 8'($urandom), 16'h0000);
                1:       beat(1'b1, 8'($urandom), 16'($urandom));
                default: beat(1'b1, 8'($urandom), 16'($urandom_range(0, 16'h0400)));
            endcase
        end
        drain();

        // Mid-frame reset at index 100, then a fully snapped frame.
        do_reset();
        for (int i = 0; i <= 100; i++) beat(1'b1, 8'($urandom), 16'($urandom_range(0, 16'h0200)));
        do_reset();
`ifdef SILENCER_SETTLED_STATUS_EN
        chk("settled_after_rst", bus.SETTLED, 1'b0);
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if ($urandom_range(0, 4) == 0) beat(1'b0, 8'h00, 16'h0000);
            beat(1'b1, 8'($urandom), 16'hFFFF);
        end
        drain();
`ifdef SILENCER_SETTLED_STATUS_EN
        chk("settled_after_snap", bus.SETTLED, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
